// File: rtl/beacon_flash_sched.sv
// Round-robin beacon flash scheduler: one prescaler and one lit beacon at a time,
// with an all-off gap between beacons. Config is accepted only while idle.
module beacon_flash_sched #(
  parameter int               WIDTH   = 16,
  parameter int               CW      = 8,
  parameter int               NUM     = 4,
  parameter logic [WIDTH-1:0] DEF_DIV = 16'd0,
  parameter logic [CW-1:0]    DEF_ON  = 8'd1,
  parameter logic [CW-1:0]    DEF_GAP = 8'd0,
  localparam int              IW      = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [CW-1:0]    cfg_on,
  input  logic [CW-1:0]    cfg_gap,
  input  logic [NUM-1:0]   cfg_mask,
  input  logic             start,
  input  logic             stop,
  output logic [NUM-1:0]   beacon,
  output logic [IW-1:0]    idx,
  output logic             busy,
  output logic             cycle_done
);

  // Handshake: a config word transfers on a clock edge where
  // cfg_valid & cfg_ready & en are all high; cfg_ready is high only in IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] div_r;
  logic [CW-1:0]    on_r;
  logic [CW-1:0]    gap_r;
  logic [NUM-1:0]   mask_r;
  logic [WIDTH-1:0] pcnt;
  logic [CW-1:0]    seg;

  logic [IW-1:0]    first_idx;
  logic [IW-1:0]    next_idx;
  logic             next_wrap;
  logic             found;
  logic [CW-1:0]    on_len;
  logic             tick;

  assign cfg_ready = (state == IDLE);
  assign on_len    = (on_r == '0) ? CW'(1) : on_r;
  assign tick      = (pcnt == '0);

  // Lowest enabled beacon, and the next enabled beacon above idx (wrapping).
  always_comb begin
    first_idx = '0;
    for (int k = NUM - 1; k >= 0; k--) begin
      if (mask_r[k]) first_idx = IW'(k);
    end
    next_idx  = idx;
    next_wrap = 1'b1;
    found     = 1'b0;
    for (int k = 1; k <= NUM; k++) begin
      if (!found && mask_r[(int'(idx) + k) % NUM]) begin
        found     = 1'b1;
        next_idx  = IW'((int'(idx) + k) % NUM);
        next_wrap = ((int'(idx) + k) >= NUM);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beacon     <= '0;
      idx        <= '0;
      busy       <= 1'b0;
      cycle_done <= 1'b0;
      div_r      <= DEF_DIV;
      on_r       <= DEF_ON;
      gap_r      <= DEF_GAP;
      mask_r     <= '1;
      pcnt       <= '0;
      seg        <= '0;
    end else if (en) begin
      cycle_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            div_r  <= cfg_div;
            on_r   <= cfg_on;
            gap_r  <= cfg_gap;
            mask_r <= cfg_mask;
          end
          // Start uses the config already latched, not a word arriving this edge.
          if (start && !stop && (mask_r != '0)) begin
            state  <= ON;
            idx    <= first_idx;
            beacon <= NUM'(1) << first_idx;
            busy   <= 1'b1;
            pcnt   <= div_r;
            seg    <= on_len;
          end
        end
        ON: begin
          if (stop) begin
            state  <= IDLE;
            beacon <= '0;
            busy   <= 1'b0;
          end else if (!tick) begin
            pcnt <= pcnt - 1'b1;
          end else begin
            pcnt <= div_r;
            if (seg > CW'(1)) begin
              seg <= seg - 1'b1;
            end else if (gap_r != '0) begin
              state  <= GAP;
              seg    <= gap_r;
              beacon <= '0;
            end else begin
              idx        <= next_idx;
              beacon     <= NUM'(1) << next_idx;
              seg        <= on_len;
              cycle_done <= next_wrap;
            end
          end
        end
        GAP: begin
          if (stop) begin
            state  <= IDLE;
            beacon <= '0;
            busy   <= 1'b0;
          end else if (!tick) begin
            pcnt <= pcnt - 1'b1;
          end else begin
            pcnt <= div_r;
            if (seg > CW'(1)) begin
              seg <= seg - 1'b1;
            end else begin
              state      <= ON;
              idx        <= next_idx;
              beacon     <= NUM'(1) << next_idx;
              seg        <= on_len;
              cycle_done <= next_wrap;
            end
          end
        end
        default: begin
          state  <= IDLE;
          beacon <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beacon_flash_sched.sv
// Directed bench for beacon_flash_sched: a vector table for the basic sequencing,
// then hand-written sequences for phase timing, lockout, freeze and mid-gap reset.
module tb_beacon_flash_sched;
  localparam int WIDTH = 16;
  localparam int CW    = 8;
  localparam int NUM   = 4;
  localparam int IW    = 2;
  localparam int NVEC  = 18;

  logic             clk = 1'b0;
  logic             rst, en, cfg_valid, start, stop;
  logic [WIDTH-1:0] cfg_div;
  logic [CW-1:0]    cfg_on, cfg_gap;
  logic [NUM-1:0]   cfg_mask;
  logic             cfg_ready, busy, cycle_done;
  logic [NUM-1:0]   beacon;
  logic [IW-1:0]    idx;

  int checks = 0;
  int passes = 0;
  logic [8:0] exp_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  beacon_flash_sched #(
    .WIDTH(WIDTH), .CW(CW), .NUM(NUM),
    .DEF_DIV(16'd0), .DEF_ON(8'd1), .DEF_GAP(8'd0)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_on(cfg_on), .cfg_gap(cfg_gap), .cfg_mask(cfg_mask),
    .start(start), .stop(stop),
    .beacon(beacon), .idx(idx), .busy(busy), .cycle_done(cycle_done)
  );

  // ctl = {rst, en, start, stop}; exp = {beacon, idx, busy, cfg_ready, cycle_done}
  typedef struct {
    logic [3:0]       ctl;
    logic             cv;
    logic [WIDTH-1:0] div;
    logic [CW-1:0]    on;
    logic [CW-1:0]    gap;
    logic [NUM-1:0]   mask;
    logic [8:0]       exp;
  } vec_t;

  vec_t vecs[NVEC];

  // Driver tasks
  task automatic drive(input logic [3:0] ctl, input logic cv, input logic [WIDTH-1:0] d,
                       input logic [CW-1:0] o, input logic [CW-1:0] g, input logic [NUM-1:0] m);
    {rst, en, start, stop} = ctl;
    cfg_valid = cv;
    cfg_div   = d;
    cfg_on    = o;
    cfg_gap   = g;
    cfg_mask  = m;
  endtask

  task automatic idle_in();
    drive(4'b0100, 1'b0, 16'd0, 8'd0, 8'd0, 4'd0);
  endtask

  task automatic step(input string name, input logic [8:0] exp);
    logic [8:0] act;
    @(posedge clk);
    #1;
    act = {beacon, idx, busy, cfg_ready, cycle_done};
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got beacon/idx/busy/ready/done=%b_%b_%b, expected %b_%b_%b",
                  name, act[8:5], act[4:3], act[2:0], exp[8:5], exp[4:3], exp[2:0]);
  endtask

  task automatic set_row(input int i, input logic [3:0] ctl, input logic cv,
                         input logic [WIDTH-1:0] d, input logic [CW-1:0] o, input logic [CW-1:0] g,
                         input logic [NUM-1:0] m, input logic [8:0] exp);
    vecs[i].ctl = ctl; vecs[i].cv = cv; vecs[i].div = d; vecs[i].on = o;
    vecs[i].gap = g; vecs[i].mask = m; vecs[i].exp = exp;
  endtask

  initial begin
    // Reset defaults, default flash order, stop priority, empty mask, on=0.
    set_row(0,  4'b1100, 1'b0, 16'd0, 8'd0, 8'd0, 4'b0000, {4'b0000, 2'd0, 3'b010});
    set_row(1,  4'b1100, 1'b0, 16'd0, 8'd0, 8'd0, 4'b0000, {4'b0000, 2'd0, 3'b010});
    set_row(2,  4'b0100, 1'b0, 16'd0, 8'd0, 8'd0, 4'b0000, {4'b0000, 2'd0, 3'b010});
    set_row(3,  4'b0110, 1'b0, 16'd0, 8'd0, 8'd0, 4'b0000, {4'b0001, 2'd0, 3'b100});
    set_row(4,  4'b0100, 1'b0, 16'd0, 8'd0, 8'd0, 4'b0000, {4'b0010, 2'd1, 3'b100});
    set_row(5,  4'b0100, 1'b0, 16'd0, 8'd0, 8'd0, 4'b0000, {4'b0100, 2'd2, 3'b100});
    set_row(6,  4'b0100, 1'b0, 16'd0, 8'd0, 8'd0, 4'b0000, {4'b1000, 2'd3, 3'b100});
    set_row(7,  4'b0100, 1'b0, 16'd0, 8'd0, 8'd0, 4'b0000, {4'b0001, 2'd0, 3'b101});
    set_row(8,  4'b0100, 1'b0, 16'd0, 8'd0, 8'd0, 4'b0000, {4'b0010, 2'd1, 3'b100});
    set_row(9,  4'b0111, 1'b0, 16'd0, 8'd0, 8'd0, 4'b0000, {4'b0000, 2'd1, 3'b010});
    set_row(10, 4'b0101, 1'b0, 16'd0, 8'd0, 8'd0, 4'b0000, {4'b0000, 2'd1, 3'b010});
    set_row(11, 4'b0100, 1'b1, 16'd0, 8'd1, 8'd0, 4'b0000, {4'b0000, 2'd1, 3'b010});
    set_row(12, 4'b0110, 1'b0, 16'd0, 8'd0, 8'd0, 4'b0000, {4'b0000, 2'd1, 3'b010});
    set_row(13, 4'b0100, 1'b1, 16'd0, 8'd0, 8'd0, 4'b0110, {4'b0000, 2'd1, 3'b010});
    set_row(14, 4'b0110, 1'b0, 16'd0, 8'd0, 8'd0, 4'b0000, {4'b0010, 2'd1, 3'b100});
    set_row(15, 4'b0100, 1'b0, 16'd0, 8'd0, 8'd0, 4'b0000, {4'b0100, 2'd2, 3'b100});
    set_row(16, 4'b0100, 1'b0, 16'd0, 8'd0, 8'd0, 4'b0000, {4'b0010, 2'd1, 3'b101});
    set_row(17, 4'b0101, 1'b0, 16'd0, 8'd0, 8'd0, 4'b0000, {4'b0000, 2'd1, 3'b010});

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].ctl, vecs[i].cv, vecs[i].div, vecs[i].on, vecs[i].gap, vecs[i].mask);
      step($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Phase timing div=3 on=2 gap=1 mask=0101, with a config attempt while busy.
    drive(4'b0100, 1'b1, 16'd3, 8'd2, 8'd1, 4'b0101);
    step("tim_cfg", {4'b0000, 2'd1, 3'b010});
    drive(4'b0110, 1'b0, 16'd0, 8'd0, 8'd0, 4'd0);
    step("tim_start", {4'b0001, 2'd0, 3'b100});
    for (int i = 0; i < 7; i++) exp_q.push_back({4'b0001, 2'd0, 3'b100});
    for (int i = 0; i < 4; i++) exp_q.push_back({4'b0000, 2'd0, 3'b100});
    for (int i = 0; i < 8; i++) exp_q.push_back({4'b0100, 2'd2, 3'b100});
    for (int i = 0; i < 4; i++) exp_q.push_back({4'b0000, 2'd2, 3'b100});
    exp_q.push_back({4'b0001, 2'd0, 3'b101});
    exp_q.push_back({4'b0001, 2'd0, 3'b100});
    for (int n = 0; exp_q.size() > 0; n++) begin
      if (n == 2) drive(4'b0100, 1'b1, 16'd0, 8'd1, 8'd0, 4'b1000);
      else idle_in();
      step($sformatf("tim%0d", n), exp_q.pop_front());
    end
    drive(4'b0101, 1'b0, 16'd0, 8'd0, 8'd0, 4'd0);
    step("tim_stop", {4'b0000, 2'd0, 3'b010});

    // Single-beacon mask loaded after stop: same beacon repeats, done every round.
    drive(4'b0100, 1'b1, 16'd0, 8'd2, 8'd0, 4'b1000);
    step("one_cfg", {4'b0000, 2'd0, 3'b010});
    drive(4'b0110, 1'b0, 16'd0, 8'd0, 8'd0, 4'd0);
    step("one_start", {4'b1000, 2'd3, 3'b100});
    for (int t = 2; t <= 7; t++) begin
      idle_in();
      step($sformatf("one%0d", t), {4'b1000, 2'd3, 2'b10, (t % 2 == 1) ? 1'b1 : 1'b0});
    end
    drive(4'b0101, 1'b0, 16'd0, 8'd0, 8'd0, 4'd0);
    step("one_stop", {4'b0000, 2'd3, 3'b010});

    // Freeze: en low for 5 clocks mid-ON; stop while frozen is not sampled.
    drive(4'b0100, 1'b1, 16'd3, 8'd2, 8'd0, 4'b0011);
    step("frz_cfg", {4'b0000, 2'd3, 3'b010});
    drive(4'b0110, 1'b0, 16'd0, 8'd0, 8'd0, 4'd0);
    step("frz_start", {4'b0001, 2'd0, 3'b100});
    for (int i = 0; i < 3; i++) begin
      idle_in();
      step($sformatf("frz_a%0d", i), {4'b0001, 2'd0, 3'b100});
    end
    for (int i = 0; i < 5; i++) begin
      drive((i == 2) ? 4'b0001 : 4'b0000, 1'b0, 16'd0, 8'd0, 8'd0, 4'd0);
      step($sformatf("frz_hold%0d", i), {4'b0001, 2'd0, 3'b100});
    end
    for (int i = 0; i < 4; i++) begin
      idle_in();
      step($sformatf("frz_b%0d", i), {4'b0001, 2'd0, 3'b100});
    end
    idle_in();
    step("frz_next", {4'b0010, 2'd1, 3'b100});
    drive(4'b0101, 1'b0, 16'd0, 8'd0, 8'd0, 4'd0);
    step("frz_stop", {4'b0000, 2'd1, 3'b010});

    // Reset during GAP returns outputs and config to defaults.
    drive(4'b0100, 1'b1, 16'd1, 8'd1, 8'd3, 4'b0100);
    step("rg_cfg", {4'b0000, 2'd1, 3'b010});
    drive(4'b0110, 1'b0, 16'd0, 8'd0, 8'd0, 4'd0);
    step("rg_start", {4'b0100, 2'd2, 3'b100});
    idle_in();
    step("rg_on", {4'b0100, 2'd2, 3'b100});
    step("rg_gap0", {4'b0000, 2'd2, 3'b100});
    step("rg_gap1", {4'b0000, 2'd2, 3'b100});
    step("rg_gap2", {4'b0000, 2'd2, 3'b100});
    drive(4'b1100, 1'b0, 16'd0, 8'd0, 8'd0, 4'd0);
    step("rg_reset", {4'b0000, 2'd0, 3'b010});
    drive(4'b0110, 1'b0, 16'd0, 8'd0, 8'd0, 4'd0);
    step("rg_def0", {4'b0001, 2'd0, 3'b100});
    idle_in();
    step("rg_def1", {4'b0010, 2'd1, 3'b100});
    step("rg_def2", {4'b0100, 2'd2, 3'b100});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/beacon_flash_sched.md
Name: beacon_flash_sched

Overview:
- Round-robin flash scheduler for the beacon LED array; owns a single tick prescaler and drives one beacon at a time.
- Each enabled beacon is lit for a programmed number of ticks, followed by an all-off gap, then the next enabled beacon is lit.
- Sits between the control/config logic and the beacon LED drivers.
- Config is accepted through a valid/ready handshake while idle; sequencing is started and stopped with pulses.

Parameters:
- WIDTH, 16, prescaler width; tick period = cfg_div+1 enabled clocks
- CW, 8, width of the on and gap tick counts
- NUM, 4, number of beacons (≥2)
- DEF_DIV, 16'd0, cfg_div value after reset
- DEF_ON, 8'd1, cfg_on value after reset
- DEF_GAP, 8'd0, cfg_gap value after reset

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- en  in  1  global enable; when low, all state freezes
- cfg_valid  in  1  config transfer request
- cfg_ready  out  1  high only in IDLE
- cfg_div  in  WIDTH  prescaler reload value
- cfg_on  in  CW  on-phase length in ticks
- cfg_gap  in  CW  gap-phase length in ticks
- cfg_mask  in  NUM  enabled beacons
- start  in  1  begin sequencing (pulse)
- stop  in  1  abort sequencing (pulse)
- beacon  out  NUM  one-hot or zero LED drive
- idx  out  $clog2(NUM)  index of the current/last beacon
- busy  out  1  high when state is ON or GAP
- cycle_done  out  1  one-cycle pulse when the sequence wraps

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE; beacon=0, idx=0, busy=0, cycle_done=0.
  - Config registers take DEF_* values; mask resets to all-ones.
  - Reset mid-sequence aborts immediately, with no further LED activity.
- Config:
  - A transfer happens on any clock edge with cfg_valid & cfg_ready & en.
  - It latches div, on, gap and mask.
  - In ON/GAP, cfg_ready=0 and the inputs are ignored.
- Prescaler:
  - Loaded with div on entering ON from IDLE.
  - On each en clock in ON/GAP: if pcnt==0, emit an internal tick and reload div; else decrement pcnt.
  - div=0 gives a tick every enabled clock.
- States:
  - IDLE:
    - start & en & !stop & mask!=0 → ON.
    - idx = lowest set mask bit; segment counter seg = max(on,1).
    - beacon is visible on the clock after start is sampled.
    - start with mask==0 is ignored.
  - ON:
    - beacon = onehot(idx).
    - On a tick: if seg>1, decrement seg.
    - Else, if gap>0 → GAP with seg=gap.
    - Else → advance idx and stay in ON with seg = max(on,1).
  - GAP:
    - beacon = 0.
    - On a tick: if seg>1, decrement seg; else advance idx and go to ON.
- Advance rule:
  - idx moves to the next set mask bit above the current one, wrapping modulo NUM.
  - cycle_done pulses for exactly one cycle, aligned with the first ON cycle of the wrapped beacon.
  - With a single-bit mask, the same beacon repeats and cycle_done pulses every round.
- Phase timing: ON lasts max(on,1)*(div+1) enabled clocks; GAP lasts gap*(div+1).
- stop:
  - In ON/GAP, stop (with en) → IDLE next edge; beacon=0, busy=0.
  - idx holds its last value.
  - stop has priority over start in the same cycle.
  - stop in IDLE has no effect.
- en low: prescaler, seg, state and outputs hold; handshake and start/stop are not sampled.
- Latched config is stable for the whole run; new config takes effect only after IDLE.

Test Plan:
- Reset defaults: rst 2 cycles → beacon=0, busy=0, cfg_ready=1; start → beacon toggles 0001→0010→0100→1000 every clock (div=0, on=1, gap=0); cycle_done pulses when 0001 returns.
- Timing, NUM=4: load div=3, on=2, gap=1, mask=0101; start → beacon=0001 for 8 clocks, 0000 for 4, 0100 for 8, 0000 for 4, then 0001 with cycle_done high for exactly that first cycle.
- Stop priority: during ON assert start and stop together → next cycle beacon=0, busy=0, cfg_ready=1, idx unchanged.
- Freeze: div=3, on=2; deassert en for 5 clocks mid-ON → beacon held; ON total = 8 enabled clocks (13 wall clocks).
- Config lockout: cfg_valid with mask=1000 while busy → ignored; after stop, load it, start → only beacon=1000, with cycle_done each round.
- Edge cases: mask=0000 then start → stays IDLE; on=0 behaves as on=1; rst asserted mid-GAP → all outputs and config return to defaults the next cycle.
